fifo_uart_tx: RTL and testbench

Downstream drain stage for the team's 8-bit synchronous FIFO. It pops one byte at a time through the FIFO's read port (`rd_en` / `empty` / `data_out`, one-cycle read latency) and serializes each byte onto a UART line: 8 data bits LSB-first, optional parity, 1 or 2 stop bits. It sits between the byte FIFO and the chip pad, and paces FIFO reads to the line rate.

---
 rtl/fifo_uart_tx_if.sv | 26 ++
 rtl/fifo_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the byte FIFO and the UART drain stage.
//
// Handshake: the FIFO holds fifo_empty=0 while it has at least one byte.
// The consumer raises fifo_rd_en for exactly one cycle, and only in a cycle
// where it has just seen fifo_empty=0. The FIFO pops on that edge and presents
// the byte on fifo_data during the following cycle (one-cycle read latency).
// There is no back-pressure on the read data: the consumer must take it then.
interface fifo_uart_tx_if;
    logic       fifo_rd_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;

    // Drain side: issues pops, consumes the flag and the data.
    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_data
    );

    // FIFO side: accepts pops, provides the flag and the data.
    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_data
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit FIFO one byte at a time and serializes each byte onto a
// UART line: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop
// bits. FIFO reads are paced to the line rate: one pop per frame.
// All outputs are registered; state is exposed on state_dbg.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done,
    output logic [2:0]            state_dbg
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    // One cycle before the end of a bit period; tx_done is set here so the
    // registered pulse lines up with the final stop-bit cycle.
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          ODD_SEL   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;   // data bit index in DATA, stop bit index in STOP
    logic [7:0]      shift;
    logic            parity_bit;
    logic            last_stop;

    assign state_dbg = state;
    assign last_stop = (bit_cnt == STOP_LAST);

    // Frame sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            baud_cnt        <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            parity_bit      <= 1'b0;
            tx              <= 1'b1;
            fifo.fifo_rd_en <= 1'b0;
            busy            <= 1'b0;
            tx_done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    tx_done <= 1'b0;
                    if (enable && !fifo.fifo_empty) begin
                        state           <= FETCH;
                        baud_cnt        <= '0;
                        fifo.fifo_rd_en <= 1'b1;
                        busy            <= 1'b1;
                    end
                end

                FETCH: begin
                    fifo.fifo_rd_en <= 1'b0;
                    baud_cnt        <= '0;
                    state           <= LOAD;
                end

                LOAD: begin
                    shift      <= fifo.fifo_data;
                    parity_bit <= (^fifo.fifo_data) ^ ODD_SEL;
                    tx         <= 1'b0;
                    baud_cnt   <= '0;
                    state      <= START;
                end

                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_cnt == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx      <= 1'b1;
                                bit_cnt <= '0;
                                state   <= STOP;
                            end
                        end else begin
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    tx <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (last_stop) begin
                            tx_done <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        if (last_stop && (baud_cnt == BAUD_PRE)) begin
                            tx_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state           <= IDLE;
                    tx              <= 1'b1;
                    fifo.fifo_rd_en <= 1'b0;
                    busy            <= 1'b0;
                    tx_done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx. Three instances share clk/rst_n:
//   a: CLKS_PER_BIT=4, no parity, 1 stop bit
//   b: CLKS_PER_BIT=4, even parity, 2 stop bits
//   c: CLKS_PER_BIT=4, odd parity, 1 stop bit
// Each has a small queue-based FIFO model with one-cycle read latency.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk;
    logic rst_n;
    logic en_a, en_b, en_c;
    logic a_tx, a_busy, a_done;
    logic b_tx, b_busy, b_done;
    logic c_tx, c_busy, c_done;
    logic [2:0] a_state, b_state, c_state;

    fifo_uart_tx_if a_if ();
    fifo_uart_tx_if b_if ();
    fifo_uart_tx_if c_if ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .fifo(a_if),
        .tx(a_tx), .busy(a_busy), .tx_done(a_done), .state_dbg(a_state));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .fifo(b_if),
        .tx(b_tx), .busy(b_busy), .tx_done(b_done), .state_dbg(b_state));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .fifo(c_if),
        .tx(c_tx), .busy(c_busy), .tx_done(c_done), .state_dbg(c_state));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- FIFO models ----------------
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    logic [7:0] c_q[$];
    int a_under = 0, b_under = 0, c_under = 0;

    always @(posedge clk) begin
        if (a_if.fifo_rd_en) begin
            if (a_q.size() > 0) a_if.fifo_data <= a_q.pop_front();
            else a_under <= a_under + 1;
        end
        a_if.fifo_empty <= (a_q.size() == 0);
    end

    always @(posedge clk) begin
        if (b_if.fifo_rd_en) begin
            if (b_q.size() > 0) b_if.fifo_data <= b_q.pop_front();
            else b_under <= b_under + 1;
        end
        b_if.fifo_empty <= (b_q.size() == 0);
    end

    always @(posedge clk) begin
        if (c_if.fifo_rd_en) begin
            if (c_q.size() > 0) c_if.fifo_data <= c_q.pop_front();
            else c_under <= c_under + 1;
        end
        c_if.fifo_empty <= (c_q.size() == 0);
    end

    // ---------------- event monitors (instance a) ----------------
    int a_rd_cnt = 0;
    int a_rd_cyc = 0;
    int a_done_cnt = 0;

    always @(negedge clk) begin
        if (a_if.fifo_rd_en === 1'b1) begin
            a_rd_cnt = a_rd_cnt + 1;
            a_rd_cyc = cyc;
        end
        if (a_done === 1'b1) a_done_cnt = a_done_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int s);
        case (s)
            0:       return a_tx;
            1:       return b_tx;
            default: return c_tx;
        endcase
    endfunction

    function automatic logic done_of(input int s);
        case (s)
            0:       return a_done;
            1:       return b_done;
            default: return c_done;
        endcase
    endfunction

    function automatic logic busy_of(input int s);
        case (s)
            0:       return a_busy;
            1:       return b_busy;
            default: return c_busy;
        endcase
    endfunction

    logic rec_tx   [0:63];
    logic rec_done [0:63];
    logic rec_busy [0:63];

    // Wait (bounded) for the start bit, then record ncyc cycles of the line.
    task automatic grab(input int s, input int ncyc, input string tag, output int fall);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 800 && !got; i++) begin
            @(negedge clk);
            if (tx_of(s) === 1'b0) got = 1'b1;
        end
        check({tag, "_start_seen"}, 32'(got), 32'd1);
        fall = cyc;
        rec_tx[0]   = tx_of(s);
        rec_done[0] = done_of(s);
        rec_busy[0] = busy_of(s);
        for (int i = 1; i < ncyc; i++) begin
            @(negedge clk);
            rec_tx[i]   = tx_of(s);
            rec_done[i] = done_of(s);
            rec_busy[i] = busy_of(s);
        end
    endtask

    // Compare the recorded frame against the hand-derived bit sequence.
    task automatic check_frame(input string tag, input logic [7:0] d, input int par_en,
                               input logic par_bit, input int nstop);
        int nb;
        int dcnt;
        int didx;
        logic e;
        logic v;
        nb = 9 + par_en + nstop;
        for (int k = 0; k < nb; k++) begin
            if (k == 0)                    e = 1'b0;
            else if (k <= 8)               e = d[k-1];
            else if (par_en != 0 && k == 9) e = par_bit;
            else                           e = 1'b1;
            v = rec_tx[k*CPB];
            for (int j = 1; j < CPB; j++) begin
                if (rec_tx[k*CPB + j] !== v) v = 1'bx;
            end
            check($sformatf("%s_bit%0d", tag, k), 32'(v), 32'(e));
        end
        dcnt = 0;
        didx = -1;
        for (int i = 0; i <= nb*CPB; i++) begin
            if (rec_done[i] === 1'b1) begin
                dcnt++;
                didx = i;
            end
        end
        check({tag, "_done_count"}, 32'(dcnt), 32'd1);
        check({tag, "_done_pos"}, 32'(didx), 32'(nb*CPB - 1));
        check({tag, "_busy_last"}, 32'(rec_busy[nb*CPB - 1]), 32'd1);
        check({tag, "_busy_fall"}, 32'(rec_busy[nb*CPB]), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int f1, f2, f3, ce;
        int rd0, d0, viol;
        bit seen;

        rst_n = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        en_c = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_a_tx",    32'(a_tx), 32'd1);
        check("rst_a_rd_en", 32'(a_if.fifo_rd_en), 32'd0);
        check("rst_a_busy",  32'(a_busy), 32'd0);
        check("rst_a_done",  32'(a_done), 32'd0);
        check("rst_a_state", 32'(a_state), 32'd0);
        check("rst_b_tx",    32'(b_tx), 32'd1);
        check("rst_c_tx",    32'(c_tx), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5
        rd0 = a_rd_cnt;
        d0  = a_done_cnt;
        a_q.push_back(8'hA5);
        en_a = 1'b1;
        grab(0, 10*CPB + 1, "t1", f1);
        check_frame("t1", 8'hA5, 0, 1'b0, 1);
        check("t1_rd_to_fall", 32'(f1 - a_rd_cyc), 32'd2);
        repeat (10) @(negedge clk);
        check("t1_rd_pulses", 32'(a_rd_cnt - rd0), 32'd1);
        check("t1_done_pulses", 32'(a_done_cnt - d0), 32'd1);

        // Three bytes back to back
        rd0 = a_rd_cnt;
        a_q.push_back(8'h00);
        a_q.push_back(8'hFF);
        a_q.push_back(8'h3C);
        grab(0, 10*CPB + 1, "t2a", f1);
        check_frame("t2a", 8'h00, 0, 1'b0, 1);
        grab(0, 10*CPB + 1, "t2b", f2);
        check_frame("t2b", 8'hFF, 0, 1'b0, 1);
        grab(0, 10*CPB + 1, "t2c", f3);
        check_frame("t2c", 8'h3C, 0, 1'b0, 1);
        check("t2_period_12", 32'(f2 - f1), 32'd43);
        check("t2_period_23", 32'(f3 - f2), 32'd43);
        repeat (20) @(negedge clk);
        check("t2_rd_pulses", 32'(a_rd_cnt - rd0), 32'd3);
        check("t2_empty", 32'(a_if.fifo_empty), 32'd1);
        check("t2_idle_busy", 32'(a_busy), 32'd0);

        // Even parity, 2 stop bits, byte 0x07
        b_q.push_back(8'h07);
        en_b = 1'b1;
        grab(1, 12*CPB + 1, "t3b", f1);
        check_frame("t3b", 8'h07, 1, 1'b1, 2);
        en_b = 1'b0;

        // Odd parity, 1 stop bit, byte 0x07
        c_q.push_back(8'h07);
        en_c = 1'b1;
        grab(2, 11*CPB + 1, "t3c", f1);
        check_frame("t3c", 8'h07, 1, 1'b0, 1);
        en_c = 1'b0;

        // Enable dropped during DATA of frame 1
        rd0 = a_rd_cnt;
        a_q.push_back(8'h5A);
        a_q.push_back(8'hC3);
        fork
            grab(0, 10*CPB + 1, "t4a", f1);
            begin
                seen = 1'b0;
                for (int i = 0; i < 800 && !seen; i++) begin
                    @(negedge clk);
                    if (a_tx === 1'b0) seen = 1'b1;
                end
                repeat (8) @(negedge clk);
                en_a = 1'b0;
            end
        join
        check_frame("t4a", 8'h5A, 0, 1'b0, 1);
        viol = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (a_tx !== 1'b1 || a_if.fifo_rd_en !== 1'b0) viol++;
        end
        check("t4_hold_quiet", 32'(viol), 32'd0);
        check("t4_hold_rd", 32'(a_rd_cnt - rd0), 32'd1);
        en_a = 1'b1;
        ce = cyc;
        grab(0, 10*CPB + 1, "t4b", f2);
        check("t4_restart_lat", 32'(f2 - ce), 32'd3);
        check_frame("t4b", 8'hC3, 0, 1'b0, 1);
        check("t4_rd_pulses", 32'(a_rd_cnt - rd0), 32'd2);

        // Reset mid-DATA
        rd0 = a_rd_cnt;
        a_q.push_back(8'h96);
        a_q.push_back(8'h81);
        seen = 1'b0;
        for (int i = 0; i < 800 && !seen; i++) begin
            @(negedge clk);
            if (a_tx === 1'b0) seen = 1'b1;
        end
        check("t5_start_seen", 32'(seen), 32'd1);
        repeat (10) @(negedge clk);
        d0 = a_done_cnt;
        rst_n = 1'b0;
        #1;
        check("t5_async_tx",    32'(a_tx), 32'd1);
        check("t5_async_busy",  32'(a_busy), 32'd0);
        check("t5_async_state", 32'(a_state), 32'd0);
        check("t5_async_rd",    32'(a_if.fifo_rd_en), 32'd0);
        repeat (3) @(negedge clk);
        check("t5_no_done", 32'(a_done_cnt - d0), 32'd0);
        rst_n = 1'b1;
        grab(0, 10*CPB + 1, "t5", f1);
        check_frame("t5", 8'h81, 0, 1'b0, 1);
        repeat (5) @(negedge clk);
        check("t5_done_after", 32'(a_done_cnt - d0), 32'd1);
        check("t5_rd_pulses", 32'(a_rd_cnt - rd0), 32'd2);

        // No pop was ever issued against an empty FIFO
        check("underflow", 32'(a_under + b_under + c_under), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
